pattern_event_logger: RTL and testbench

- Downstream consumer of the 4-bit nibble pattern detector.
- Stamps each sequence_detected pulse with the index of the current input beat, and buffers the stamps in a small first-word-fall-through (FWFT) FIFO.
- A host or scoreboard reads the stamps over a valid/ready port.
- Also keeps saturating totals of detections and dropped events, plus a sticky overflow flag.

---
 rtl/pattern_event_logger.sv | 106 ++++++++++
 tb/tb_pattern_event_logger.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pattern_event_logger.sv
// Timestamps detector pulses with the current input-beat index and queues the
// stamps in a small first-word-fall-through FIFO, with saturating event/drop totals.
module pattern_event_logger #(
   parameter int TS_W  = 16,
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     in_valid,
   input  logic                     det,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [TS_W-1:0]          out_ts,
   output logic [$clog2(DEPTH):0]   fill,
   output logic [CNT_W-1:0]         event_cnt,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);

   logic [TS_W-1:0] beat_cnt;
   logic [TS_W-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   rd_next;
   logic            pop;
   logic            push;
   logic            drop;

   // A full FIFO still accepts when the head leaves on the same edge.
   assign pop       = out_valid & out_ready;
   assign push      = det & ((fill != FULL) | pop);
   assign drop      = det & ~push;
   assign rd_next   = rd_ptr + AW'(1);
   assign out_valid = (fill != '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of block order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill      <= '0;
         out_ts    <= '0;
         event_cnt <= '0;
         drop_cnt  <= '0;
         overflow  <= 1'b0;
      end else if (clr) begin
         beat_cnt  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill      <= '0;
         out_ts    <= '0;
         event_cnt <= '0;
         drop_cnt  <= '0;
         overflow  <= 1'b0;
      end else begin
         if (in_valid)
            beat_cnt <= beat_cnt + TS_W'(1);

         if (det && event_cnt != '1)
            event_cnt <= event_cnt + CNT_W'(1);

         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1)
               drop_cnt <= drop_cnt + CNT_W'(1);
         end

         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_next;

         case ({push, pop})
            2'b10:   fill <= fill + ONE;
            2'b01:   fill <= fill - ONE;
            default: fill <= fill;
         endcase

         // out_ts is a register holding the head, so it keeps its last value once empty.
         if (push && fill == '0)
            out_ts <= beat_cnt;
         else if (pop) begin
            if (fill > ONE)
               out_ts <= mem[rd_next];
            else if (push)
               out_ts <= beat_cnt;
         end
      end
   end

   // NOTE: the storage array has no reset; an entry is only ever read after
   // it has been written, and the visible head lives in the out_ts register.
   always_ff @(posedge clk) begin
      if (push && !clr)
         mem[wr_ptr] <= beat_cnt;
   end

endmodule

// File: tb/tb_pattern_event_logger.sv
// Directed bench for pattern_event_logger: one default-width instance plus a
// narrow (TS_W=4, CNT_W=4) instance for wrap and saturation.
module tb_pattern_event_logger;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic        det = 1'b0;
   logic        out_ready = 1'b0;

   logic        out_valid;
   logic [15:0] out_ts;
   logic [3:0]  fill;
   logic [15:0] event_cnt;
   logic [15:0] drop_cnt;
   logic        overflow;

   logic        out_valid_w;
   logic [3:0]  out_ts_w;
   logic [3:0]  fill_w;
   logic [3:0]  event_cnt_w;
   logic [3:0]  drop_cnt_w;
   logic        overflow_w;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pattern_event_logger dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .det(det),
      .out_ready(out_ready), .out_valid(out_valid), .out_ts(out_ts),
      .fill(fill), .event_cnt(event_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
   );

   pattern_event_logger #(.TS_W(4), .DEPTH(8), .CNT_W(4)) dut_w (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .det(det),
      .out_ready(out_ready), .out_valid(out_valid_w), .out_ts(out_ts_w),
      .fill(fill_w), .event_cnt(event_cnt_w), .drop_cnt(drop_cnt_w), .overflow(overflow_w)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      // 1: asynchronous reset in the middle of operation
      #12 rst = 1'b1;
      tick();
      in_valid = 1'b1; det = 1'b1;
      tick(3);
      in_valid = 1'b0; det = 1'b0;
      check("t1_fill_loaded", fill, 3);
      check("t1_head_loaded", out_ts, 0);
      #2 rst = 1'b0;
      #1;
      check("t1_rst_valid", out_valid, 0);
      check("t1_rst_fill", fill, 0);
      check("t1_rst_event", event_cnt, 0);
      check("t1_rst_ts", out_ts, 0);
      tick();
      rst = 1'b1;
      det = 1'b1;
      tick();
      det = 1'b0;
      check("t1_stamp_valid", out_valid, 1);
      check("t1_stamp_ts", out_ts, 0);
      check("t1_stamp_fill", fill, 1);

      // 2: basic stamping and pop
      do_clr();
      check("t2_clr_fill", fill, 0);
      in_valid = 1'b1;
      tick(5);
      in_valid = 1'b0; det = 1'b1;
      tick();
      det = 1'b0;
      check("t2_valid", out_valid, 1);
      check("t2_ts", out_ts, 5);
      check("t2_fill", fill, 1);
      check("t2_event", event_cnt, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t2_pop_valid", out_valid, 0);
      check("t2_pop_fill", fill, 0);
      check("t2_pop_ts_hold", out_ts, 5);

      // 3: back-to-back detections on consecutive beats
      do_clr();
      in_valid = 1'b1;
      tick(10);
      det = 1'b1;
      tick(3);
      det = 1'b0; in_valid = 1'b0;
      check("t3_event", event_cnt, 3);
      check("t3_fill", fill, 3);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t3_order%0d", i), out_ts, 10 + i);
         tick();
      end
      out_ready = 1'b0;
      check("t3_empty", out_valid, 0);

      // 4: overflow with consumer stalled, then drain
      do_clr();
      in_valid = 1'b1; det = 1'b1;
      tick(10);
      in_valid = 1'b0; det = 1'b0;
      check("t4_fill", fill, 8);
      check("t4_drop", drop_cnt, 2);
      check("t4_overflow", overflow, 1);
      check("t4_event", event_cnt, 10);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t4_drain%0d", i), out_ts, i);
         tick();
      end
      out_ready = 1'b0;
      check("t4_drained_fill", fill, 0);
      check("t4_overflow_sticky", overflow, 1);

      // 5: full FIFO with a same-edge pop, then clear racing a detection
      do_clr();
      in_valid = 1'b1; det = 1'b1;
      tick(8);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0; det = 1'b0;
      check("t5_full_fill", fill, 8);
      check("t5_no_drop", drop_cnt, 0);
      check("t5_no_overflow", overflow, 0);
      check("t5_event", event_cnt, 9);
      check("t5_head", out_ts, 1);
      for (int i = 0; i < 7; i++) begin
         check($sformatf("t5_drain%0d", i), out_ts, 1 + i);
         tick();
      end
      out_ready = 1'b0;
      check("t5_tail_ts", out_ts, 8);
      check("t5_tail_fill", fill, 1);
      clr = 1'b1; det = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      tick();
      clr = 1'b0; det = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      check("t5_clr_fill", fill, 0);
      check("t5_clr_valid", out_valid, 0);
      check("t5_clr_event", event_cnt, 0);
      check("t5_clr_ts", out_ts, 0);
      det = 1'b1;
      tick();
      det = 1'b0;
      check("t5_beat_cleared", out_ts, 0);

      // 6: 4-bit timestamp wrap and 4-bit counter saturation
      do_clr();
      in_valid = 1'b1;
      tick(17);
      in_valid = 1'b0; det = 1'b1;
      tick();
      check("t6_wrap_ts", out_ts_w, 1);
      tick(14);
      check("t6_event_max", event_cnt_w, 15);
      tick();
      det = 1'b0;
      check("t6_event_sat", event_cnt_w, 15);
      check("t6_drop", drop_cnt_w, 8);
      check("t6_fill", fill_w, 8);
      check("t6_overflow", overflow_w, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
